// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter and capture stage for four requesters whose data
//   words go through an external 4:1 mux (Mux_4x1). The arbiter drives the
//   mux select, takes the mux output back and registers the chosen word.
//   The word is then presented on one valid/ready output channel, tagged
//   with the index of the port it came from.
//
// Optional feature (macro RR_MUX_ARBITER_CNT_EN):
//   adds the grant_cnt port and one saturating accepted-grant counter per
//   port. When the macro is undefined, the port and the counters are absent.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [3:0] per-port request (port i -> Mux_4x1 in(i+1))
//   req_ready  out  [3:0] one-hot accept pulse, word on port i taken
//   sel        out  [1:0] registered select to Mux_4x1.sel
//   mux_out    in   [DATA_W-1:0] from Mux_4x1.out
//   out_data   out  [DATA_W-1:0] captured word
//   out_src    out  [1:0] port index of out_data
//   out_valid  out  out_data/out_src valid
//   out_ready  in   downstream accept
//   grant_cnt  out  [4*CNT_W-1:0] per-port grant counters (macro only)
module rr_mux_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req_valid,
  output logic [3:0]        req_ready,
  output logic [1:0]        sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready
`ifdef RR_MUX_ARBITER_CNT_EN
  ,
  output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;

  state_t     state, state_nxt;
  logic [1:0] src;         // granted port; also drives the mux select
  logic [1:0] last_grant;  // last port whose word was actually captured
  logic [1:0] winner;
  logic       any_req;
  logic       load_sel;
  logic       capture;
  logic       release_out;

  // Pick the first requesting port after 'last', wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_req = |req_valid;
  assign winner  = rr_pick(req_valid, last_grant);
  assign sel     = src;

  // Next state, accept pulse and register-load strobes.
  always_comb begin
    state_nxt   = state;
    load_sel    = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    req_ready   = 4'b0000;
    case (state)
      IDLE: begin
        if (any_req) begin
          load_sel  = 1'b1;
          state_nxt = SEL;
        end
      end
      SEL: begin
        // A request withdrawn during SEL is dropped without a grant.
        if (req_valid[src]) begin
          req_ready[src] = 1'b1;
          capture        = 1'b1;
          state_nxt      = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          if (any_req) begin
            load_sel  = 1'b1;
            state_nxt = SEL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, select and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src        <= 2'd0;
      last_grant <= 2'd3;
      out_data   <= '0;
      out_src    <= 2'd0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_sel) src <= winner;
      if (capture) begin
        out_data   <= mux_out;
        out_src    <= src;
        out_valid  <= 1'b1;
        last_grant <= src;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_ARBITER_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Grant counters, saturating at all-ones and cleared only by reset.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt[i*CNT_W +: CNT_W] <= '0;
      end else if (req_ready[i]) begin
        grant_cnt[i*CNT_W +: CNT_W] <= sat_inc(grant_cnt[i*CNT_W +: CNT_W]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [1:0]  sel;
  logic [31:0] mux_out;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  int total;
  int bad;

`ifdef RR_MUX_ARBITER_CNT_EN
  logic [63:0] grant_cnt;
  logic [3:0]  req_ready2;
  logic [1:0]  sel2;
  logic [31:0] out_data2;
  logic [1:0]  out_src2;
  logic        out_valid2;
  logic [7:0]  grant_cnt2;
`endif

  rr_mux_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_MUX_ARBITER_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

`ifdef RR_MUX_ARBITER_CNT_EN
  rr_mux_arbiter #(.DATA_W(32), .CNT_W(2)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready2),
    .sel       (sel2),
    .mux_out   (mux_out),
    .out_data  (out_data2),
    .out_src   (out_src2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .grant_cnt (grant_cnt2)
  );
`endif

  // Mux_4x1 model: in1..in4 = 54, 67, 89, 68
  assign mux_out = (sel == 2'd0) ? 32'd54 :
                   (sel == 2'd1) ? 32'd67 :
                   (sel == 2'd2) ? 32'd89 : 32'd68;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", sel); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (out_src !== 2'd0) begin bad++; $display("FAIL reset_out_src got=%0d want=0", out_src); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    req_valid = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d want=2", sel); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    total++; if (out_data !== 32'd89) begin bad++; $display("FAIL single_data got=%0d want=89", out_data); end
    total++; if (out_src !== 2'd2) begin bad++; $display("FAIL single_src got=%0d want=2", out_src); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_hold got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_hold_valid got=%0b want=1", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_src  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_data [5] = '{32'd54, 32'd67, 32'd89, 32'd68, 32'd54};
    logic [3:0]  exp_rdy  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (req_ready !== exp_rdy[i] || out_valid !== 1'b0) begin bad++; $display("FAIL rr_sel_phase[%0d] ready=%b valid=%0b want ready=%b valid=0", i, req_ready, out_valid, exp_rdy[i]); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0b want=1", i, out_valid); end
      total++; if (out_src !== exp_src[i]) begin bad++; $display("FAIL rr_src[%0d] got=%0d want=%0d", i, out_src, exp_src[i]); end
      total++; if (out_data !== exp_data[i]) begin bad++; $display("FAIL rr_data[%0d] got=%0d want=%0d", i, out_data, exp_data[i]); end
    end
  endtask

  // Continues from the HOLD state left by test_fairness (port 0 held).
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== 32'd54 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold[%0d] valid=%0b data=%0d src=%0d ready=%b want 1/54/0/0000", i, out_valid, out_data, out_src, req_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL bp_next_sel got=%0d want=1", sel); end
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_ready got=%b want=0010", req_ready); end
    @(posedge clk); #1;
    total++; if (out_src !== 2'd1 || out_data !== 32'd67) begin bad++; $display("FAIL bp_next_word src=%0d data=%0d want 1/67", out_src, out_data); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_withdrawn();
    do_reset();
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #1;
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL wd_sel got=%0d want=1", sel); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL wd_ready got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wd_valid got=%0b want=0", out_valid); end
    req_valid = 4'b1111;
    @(posedge clk); #1;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL wd_regrant_sel got=%0d want=0", sel); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wd_regrant_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'd54) begin
      bad++; $display("FAIL wd_word valid=%0b src=%0d data=%0d want 1/0/54", out_valid, out_src, out_data);
    end
  endtask

  // Continues from HOLD (port 0 held, all ports requesting).
  task automatic test_async_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_src !== 2'd1 || sel !== 2'd1) begin
      bad++; $display("FAIL ar_pre valid=%0b src=%0d sel=%0d want 1/1/1", out_valid, out_src, sel);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0b want=0", out_valid); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL ar_sel got=%0d want=0", sel); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ar_ready got=%b want=0000", req_ready); end
    total++; if (out_src !== 2'd0 || out_data !== 32'd0) begin bad++; $display("FAIL ar_word src=%0d data=%0d want 0/0", out_src, out_data); end
    @(posedge clk); #1;
    total++; if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin bad++; $display("FAIL ar_held ready=%b valid=%0b want 0000/0", req_ready, out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (sel !== 2'd0 || req_ready !== 4'b0001) begin bad++; $display("FAIL ar_first sel=%0d ready=%b want 0/0001", sel, req_ready); end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_drain got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

`ifdef RR_MUX_ARBITER_CNT_EN
  task automatic test_counters();
    do_reset();
    total++; if (grant_cnt !== 64'd0) begin bad++; $display("FAIL cnt_reset got=%h want=0", grant_cnt); end
    out_ready = 1'b1;
    req_valid = 4'b1000;
    repeat (10) @(posedge clk);
    #1 req_valid = 4'b0010;
    repeat (4) @(posedge clk);
    #1 req_valid = 4'b0000;
    @(posedge clk); #1;
    total++; if (grant_cnt !== {16'd5, 16'd0, 16'd2, 16'd0}) begin bad++; $display("FAIL cnt_fields got=%h want=0005000000020000", grant_cnt); end
    total++; if (grant_cnt2 !== {2'd3, 2'd0, 2'd2, 2'd0}) begin bad++; $display("FAIL cnt_saturate got=%b want=11001000", grant_cnt2); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_withdrawn();
    test_async_reset();
`ifdef RR_MUX_ARBITER_CNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
